// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, command codes and timing defaults for the LCD write controller
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    POLL,
    DONE
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_MASK = 8'hFE;

  localparam int LCD_BUS_4BIT_DEF = 0;
  localparam int LCD_T_AS_DEF     = 2;
  localparam int LCD_T_PW_DEF     = 16;
  localparam int LCD_T_H_DEF      = 2;
  localparam int LCD_T_EXEC_DEF   = 2000;
  localparam int LCD_T_CLR_DEF    = 82000;

  function automatic int lcd_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Clear-display and return-home (either value of the don't-care bit) need the long wait.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == LCD_CMD_CLEAR) || ((b & LCD_CMD_HOME_MASK) == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter with zero flag shared by all timed controller states
module lcd_timer #(
  parameter int CW = 8
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)         cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// rtl/lcd_bus_ctrl.sv - HD44780-class LCD write controller; LCD_BUSY_POLL_EN swaps the fixed wait for busy-flag polling
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int BUS_4BIT = LCD_BUS_4BIT_DEF,
  parameter int T_AS     = LCD_T_AS_DEF,
  parameter int T_PW     = LCD_T_PW_DEF,
  parameter int T_H      = LCD_T_H_DEF,
  parameter int T_EXEC   = LCD_T_EXEC_DEF,
  parameter int T_CLR    = LCD_T_CLR_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iNib,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  input  logic [7:0] iLCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam int CW = $clog2(lcd_max4(T_CLR, T_PW, T_AS, T_H) + 1);

  lcd_state_t    state, nstate;
  logic [7:0]    data_q;
  logic [3:0]    lo_q;
  logic          rs_q, long_q, nib2_q;
  logic          tload, tzero, wait_zero;
  logic [CW-1:0] tval;

`ifdef LCD_BUSY_POLL_EN
  logic          poll_q, busy_q;
  logic [CW-1:0] wd_q;
  wire           unused_rd = ^iLCD_DATA[6:0];
`else
  wire           unused_rd = ^iLCD_DATA;
`endif

  lcd_timer #(.CW(CW)) u_timer (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  assign wait_zero = long_q ? (T_CLR == 0) : (T_EXEC == 0);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    tload  = 1'b0;
    tval   = '0;
    unique case (state)
      IDLE:  if (iValid) begin nstate = SETUP; tload = 1'b1; tval = CW'(T_AS - 1); end
      SETUP: if (tzero)  begin nstate = PULSE; tload = 1'b1; tval = CW'(T_PW - 1); end
      PULSE: if (tzero)  begin nstate = HOLD;  tload = 1'b1; tval = CW'(T_H - 1);  end
      HOLD: begin
        if (tzero) begin
          if (nib2_q) begin
            nstate = SETUP; tload = 1'b1; tval = CW'(T_AS - 1);
          end
`ifdef LCD_BUSY_POLL_EN
          else if (poll_q) begin
            nstate = POLL;
          end else begin
            nstate = SETUP; tload = 1'b1; tval = CW'(T_AS - 1);
          end
`else
          else if (wait_zero) begin
            nstate = DONE;
          end else begin
            nstate = EXEC; tload = 1'b1;
            tval   = long_q ? CW'(T_CLR - 1) : CW'(T_EXEC - 1);
          end
`endif
        end
      end
      EXEC:  if (tzero) nstate = DONE;
`ifdef LCD_BUSY_POLL_EN
      // A stuck busy flag is abandoned once the watchdog has drained.
      POLL: begin
        if (!busy_q || wd_q == '0) nstate = DONE;
        else begin nstate = SETUP; tload = 1'b1; tval = CW'(T_AS - 1); end
      end
`endif
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      data_q <= '0;
      lo_q   <= '0;
      rs_q   <= 1'b0;
      long_q <= 1'b0;
      nib2_q <= 1'b0;
    end else if (state == IDLE && iValid) begin
      rs_q   <= iRS;
      long_q <= lcd_is_long_cmd(iRS, iDATA) && !((BUS_4BIT != 0) && iNib);
      if (BUS_4BIT != 0) begin
        data_q <= {iDATA[7:4], 4'h0};
        lo_q   <= iDATA[3:0];
        nib2_q <= !iNib;
      end else begin
        data_q <= iDATA;
        lo_q   <= 4'h0;
        nib2_q <= 1'b0;
      end
    end else if (state == HOLD && tzero) begin
      if (nib2_q) begin
        data_q <= {lo_q, 4'h0};
        nib2_q <= 1'b0;
      end
`ifdef LCD_BUSY_POLL_EN
      else if (!poll_q) begin
        data_q <= '0;
        lo_q   <= '0;
        rs_q   <= 1'b0;
        nib2_q <= (BUS_4BIT != 0);
      end
`endif
    end
`ifdef LCD_BUSY_POLL_EN
    else if (state == POLL) begin
      nib2_q <= (BUS_4BIT != 0);
    end
`endif
  end

`ifdef LCD_BUSY_POLL_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      poll_q <= 1'b0;
      busy_q <= 1'b0;
      wd_q   <= '0;
    end else begin
      if (state == HOLD && tzero && !nib2_q && !poll_q) begin
        poll_q <= 1'b1;
        wd_q   <= CW'(T_CLR);
      end else if (wd_q != '0) begin
        wd_q <= wd_q - 1'b1;
      end
      // The flag lives on D7 of the first (or only) read nibble.
      if (state == PULSE && tzero && poll_q && ((BUS_4BIT == 0) || nib2_q))
        busy_q <= iLCD_DATA[7];
      if (state == DONE)
        poll_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    oReady   = iRST_N && (state == IDLE);
    oBusy    = !oReady;
    oDone    = (state == DONE);
    LCD_EN   = (state == PULSE);
    LCD_DATA = data_q;
    LCD_RS   = rs_q;
`ifdef LCD_BUSY_POLL_EN
    LCD_RW   = poll_q;
`else
    LCD_RW   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb/tb_lcd_bus_ctrl.sv - scoreboard bench for lcd_bus_ctrl over three timing/bus configurations
module tb_lcd_bus_ctrl;

  localparam int NI = 3;
  localparam int BOUND = 5000;
  localparam int P4  [NI] = '{0, 0, 1};
  localparam int TAS [NI] = '{2, 1, 2};
  localparam int TPW [NI] = '{16, 2, 3};
  localparam int TH  [NI] = '{2, 1, 1};
  localparam int TEX [NI] = '{2000, 10, 0};
  localparam int TCL [NI] = '{82000, 60, 25};

  typedef struct {
    int         id;
    bit         is_done;
    logic [7:0] data;
    logic       rs;
    int         cyc;
  } exp_t;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] din    [NI];
  logic       rs_in  [NI];
  logic       nib_in [NI];
  logic       valid  [NI];
  logic       ready  [NI];
  logic       done   [NI];
  logic       busy   [NI];
  logic       en     [NI];
  logic       rw     [NI];
  logic       rs_o   [NI];
  logic [7:0] ldata  [NI];
  logic [7:0] rdback = 8'h00;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   gcyc = 0;
  int   cyc     [NI];
  int   en_w    [NI];
  int   last_dn [NI];
  bit   en_p    [NI];
  bit   done_p  [NI];
  logic [7:0] dat_r [NI];
  logic rs_r [NI];
  bit   b2b_chk = 0;

  always #5 iCLK = ~iCLK;

  lcd_bus_ctrl u_dut0 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(din[0]), .iRS(rs_in[0]), .iNib(nib_in[0]),
    .iValid(valid[0]), .oReady(ready[0]), .oDone(done[0]), .oBusy(busy[0]),
    .LCD_DATA(ldata[0]), .iLCD_DATA(rdback), .LCD_RW(rw[0]), .LCD_RS(rs_o[0]), .LCD_EN(en[0])
  );

  lcd_bus_ctrl #(.BUS_4BIT(P4[1]), .T_AS(TAS[1]), .T_PW(TPW[1]), .T_H(TH[1]),
                 .T_EXEC(TEX[1]), .T_CLR(TCL[1])) u_dut1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(din[1]), .iRS(rs_in[1]), .iNib(nib_in[1]),
    .iValid(valid[1]), .oReady(ready[1]), .oDone(done[1]), .oBusy(busy[1]),
    .LCD_DATA(ldata[1]), .iLCD_DATA(rdback), .LCD_RW(rw[1]), .LCD_RS(rs_o[1]), .LCD_EN(en[1])
  );

  lcd_bus_ctrl #(.BUS_4BIT(P4[2]), .T_AS(TAS[2]), .T_PW(TPW[2]), .T_H(TH[2]),
                 .T_EXEC(TEX[2]), .T_CLR(TCL[2])) u_dut2 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(din[2]), .iRS(rs_in[2]), .iNib(nib_in[2]),
    .iValid(valid[2]), .oReady(ready[2]), .oDone(done[2]), .oBusy(busy[2]),
    .LCD_DATA(ldata[2]), .iLCD_DATA(rdback), .LCD_RW(rw[2]), .LCD_RS(rs_o[2]), .LCD_EN(en[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle 1 is the first cycle after the handshake edge.
  task automatic push_expect(input int g, input logic [7:0] d, input logic rs, input logic nib,
                             output logic [7:0] last);
    int   passes, wt, sum;
    exp_t e;
    passes = (P4[g] != 0 && !nib) ? 2 : 1;
    if (P4[g] != 0 && nib)                          wt = TEX[g];
    else if (!rs && (d == 8'h01 || d[7:1] == 7'h01)) wt = TCL[g];
    else                                             wt = TEX[g];
    sum = TAS[g] + TPW[g] + TH[g];
    for (int p = 0; p < passes; p++) begin
      e.id = g; e.is_done = 0; e.rs = rs; e.cyc = p * sum + TAS[g] + 1;
      if (P4[g] == 0) e.data = d;
      else            e.data = (p == 0) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
      last = e.data;
      sb.push_back(e);
    end
    e.id = g; e.is_done = 1; e.data = 8'h00; e.rs = 1'b0; e.cyc = passes * sum + wt + 1;
    sb.push_back(e);
  endtask

  always @(negedge iCLK) begin : mon
    exp_t e;
    gcyc++;
    for (int g = 0; g < NI; g++) begin
      cyc[g]++;
      if (!iRST_N) begin
        en_p[g] = 0;
        done_p[g] = 0;
      end else begin
        if (done_p[g]) check("done_1cyc", done[g], 0);
        if (en[g] && !en_p[g]) begin
          check("pulse_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pulse_id", e.is_done ? 99 : e.id, g);
            check("pulse_data", ldata[g], e.data);
            check("pulse_rs", rs_o[g], e.rs);
            check("pulse_start", cyc[g], e.cyc);
            check("pulse_rw", rw[g], 0);
          end
          en_w[g] = 1; dat_r[g] = ldata[g]; rs_r[g] = rs_o[g];
        end else if (en[g]) begin
          en_w[g]++;
          check("pulse_stable", {ldata[g], rs_o[g]}, {dat_r[g], rs_r[g]});
        end
        if (!en[g] && en_p[g]) check("pulse_width", en_w[g], TPW[g]);
        if (done[g]) begin
          check("done_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("done_id", e.is_done ? e.id : 99, g);
            check("done_cyc", cyc[g], e.cyc);
          end
          last_dn[g] = gcyc;
        end
        if (valid[g] && ready[g]) begin
          if (b2b_chk) check("b2b_gap", gcyc - last_dn[g], 1);
          cyc[g] = 0;
        end
        en_p[g] = en[g];
        done_p[g] = done[g];
      end
    end
  end

  task automatic wait_hs(input int g, output bit got);
    got = 0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge iCLK);
      if (ready[g]) begin got = 1; break; end
    end
  endtask

  task automatic wait_done(input int g, output bit got);
    got = 0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge iCLK);
      if (done[g]) begin got = 1; break; end
    end
  endtask

  task automatic send(input int g, input logic [7:0] d, input logic rs, input logic nib, input bit noise);
    logic [7:0] last;
    bit got;
    push_expect(g, d, rs, nib, last);
    @(posedge iCLK); #1;
    din[g] = d; rs_in[g] = rs; nib_in[g] = nib; valid[g] = 1'b1;
    wait_hs(g, got);
    check("handshake", got, 1);
    @(posedge iCLK); #1;
    valid[g] = 1'b0; din[g] = ~d; rs_in[g] = ~rs; nib_in[g] = ~nib;
    if (noise) begin
      repeat (3) @(posedge iCLK);
      #1 valid[g] = 1'b1; din[g] = 8'hFF;
      repeat (2) @(posedge iCLK);
      #1 valid[g] = 1'b0;
    end
    wait_done(g, got);
    check("done_seen", got, 1);
    @(negedge iCLK);
    check("ready_after", ready[g], 1);
    check("busy_after", busy[g], 0);
    check("idle_data", ldata[g], last);
    check("idle_rs", rs_o[g], rs);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic b2b(input int g, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] last;
    bit got;
    push_expect(g, d1, 1'b1, 1'b0, last);
    push_expect(g, d2, 1'b0, 1'b0, last);
    @(posedge iCLK); #1;
    din[g] = d1; rs_in[g] = 1'b1; nib_in[g] = 1'b0; valid[g] = 1'b1;
    wait_hs(g, got);
    check("b2b_hs1", got, 1);
    @(posedge iCLK); #1;
    din[g] = d2; rs_in[g] = 1'b0; b2b_chk = 1;
    wait_done(g, got);
    check("b2b_done1", got, 1);
    wait_hs(g, got);
    check("b2b_hs2", got, 1);
    @(posedge iCLK); #1;
    valid[g] = 1'b0;
    wait_done(g, got);
    b2b_chk = 0;
    check("b2b_done2", got, 1);
    @(negedge iCLK);
    check("b2b_idle_data", ldata[g], last);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    bit got;
    int cnt;
    logic [7:0] last;
    for (int g = 0; g < NI; g++) begin
      din[g] = 8'h00; rs_in[g] = 1'b0; nib_in[g] = 1'b0; valid[g] = 1'b0;
      cyc[g] = 0; en_w[g] = 0; last_dn[g] = 0; en_p[g] = 0; done_p[g] = 0;
      dat_r[g] = 8'h00; rs_r[g] = 1'b0;
    end
    repeat (3) @(negedge iCLK);
    for (int g = 0; g < NI; g++) begin
      check("rst_ready", ready[g], 0);
      check("rst_done", done[g], 0);
      check("rst_en", en[g], 0);
      check("rst_data", ldata[g], 8'h00);
      check("rst_rs_rw", {rs_o[g], rw[g]}, 2'b00);
    end
    @(posedge iCLK); #1 iRST_N = 1'b1;
    @(negedge iCLK);
    for (int g = 0; g < NI; g++) check("post_rst_ready", ready[g], 1);

    send(0, 8'h41, 1'b1, 1'b0, 1'b0);

    send(1, 8'h01, 1'b0, 1'b0, 1'b0);
    send(1, 8'h02, 1'b0, 1'b0, 1'b0);
    send(1, 8'h03, 1'b0, 1'b0, 1'b0);
    send(1, 8'h06, 1'b0, 1'b0, 1'b1);
    send(1, 8'h01, 1'b1, 1'b0, 1'b0);
    send(1, 8'h01, 1'b0, 1'b1, 1'b0);
    b2b(1, 8'h48, 8'h06);

    send(2, 8'hA5, 1'b1, 1'b0, 1'b0);
    send(2, 8'h01, 1'b0, 1'b0, 1'b0);
    send(2, 8'h30, 1'b0, 1'b1, 1'b0);
    send(2, 8'h01, 1'b0, 1'b1, 1'b0);

    push_expect(1, 8'h55, 1'b1, 1'b0, last);
    @(posedge iCLK); #1;
    din[1] = 8'h55; rs_in[1] = 1'b1; nib_in[1] = 1'b0; valid[1] = 1'b1;
    wait_hs(1, got);
    check("rst_hs", got, 1);
    @(posedge iCLK); #1 valid[1] = 1'b0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge iCLK);
      if (en[1]) begin got = 1; break; end
    end
    check("rst_en_seen", got, 1);
    #2 iRST_N = 1'b0;
    #1;
    check("async_en", en[1], 0);
    check("async_ready", ready[1], 0);
    check("async_done", done[1], 0);
    sb.delete();
    repeat (2) @(posedge iCLK);
    #3 iRST_N = 1'b1;
    @(negedge iCLK);
    check("rel_ready", ready[1], 1);
    check("rel_done", done[1], 0);
    check("rel_en", en[1], 0);
    check("rel_data", {ldata[1], rs_o[1]}, 9'h000);
    cnt = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (en[1] || done[1]) cnt++;
    end
    check("no_residual", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
